// File: rtl/controller_pkg.sv
// Shared definitions for the multi-cycle controller: FSM state encoding,
// opcode map and ALU function-select codes.
package controller_pkg;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_BRZ  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] FS_ADD = 3'd0;
  localparam logic [2:0] FS_SUB = 3'd1;
  localparam logic [2:0] FS_AND = 3'd2;
  localparam logic [2:0] FS_OR  = 3'd3;
  localparam logic [2:0] FS_XOR = 3'd4;
  localparam logic [2:0] FS_NOT = 3'd5;
  localparam logic [2:0] FS_SHL = 3'd6;

  // ALU opcodes 1..7 map directly onto FS codes 0..6
  function automatic logic [2:0] alu_fs(input logic [3:0] op);
    return op[2:0] - 3'd1;
  endfunction

  // LD and ST are the only instructions that wait on data memory
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/call_stack.sv
// Return-address LIFO for CALL/RET. The caller never pushes and pops in the
// same cycle and never pushes when full or pops when empty; the guards here
// only keep the occupancy counter consistent if that is ever violated.
module call_stack #(
  parameter int PC_W        = 6,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic [CNT_W-1:0] cnt;
  logic [PC_W-1:0]  mem [STACK_DEPTH];

  assign full  = (cnt == CNT_W'(STACK_DEPTH));
  assign empty = (cnt == '0);

  // Occupancy counter: the only control state of the stack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + CNT_W'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Entry storage: written at the slot just above the current top
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push && !full && (cnt == CNT_W'(i))) begin
        mem[i] <= din;
      end
    end
  end

  // Most recently pushed entry, zero when the stack is empty
  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (cnt == CNT_W'(i + 1)) begin
        top = mem[i];
      end
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle datapath controller: BOOT/FETCH/DECODE/EXEC/HALT sequencer with
// PC, IR, conditional branch, CALL/RET through a return-address stack,
// memory-wait stall on LD/ST and sticky stack-error reporting.
module multicycle_controller
  import controller_pkg::*;
#(
  parameter int NBIT        = 16,
  parameter int PC_W        = 6,
  parameter int RA_W        = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NBIT-1:0] data_from_rom,
  input  logic [NBIT-1:0] A,
  input  logic            zero_flag,
  input  logic            mem_ready,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] PC_prev,
  output logic [RA_W-1:0] DA,
  output logic [RA_W-1:0] AA,
  output logic [RA_W-1:0] BA,
  output logic [2:0]      FS,
  output logic            IL,
  output logic            RW,
  output logic            MB,
  output logic            MD,
  output logic            MM,
  output logic            MW,
  output logic            done,
  output logic            stack_err
);

  if (NBIT != 4 + 3 * RA_W) begin : g_bad_width
    $error("NBIT must equal 4 + 3*RA_W");
  end

  state_t                  state, state_nxt;
  logic [NBIT-1:0]         ir;
  logic [3:0]              op;
  logic signed [2*RA_W-1:0] br_off;
  logic [PC_W-1:0]         br_target;
  logic [PC_W-1:0]         jmp_target;
  logic                    mem_wait;
  logic                    stk_push, stk_pop, stk_full, stk_empty, stk_fault;
  logic [PC_W-1:0]         stk_top;
  logic                    unused_a_hi;

  assign op = ir[NBIT-1 -: 4];
  assign DA = ir[3*RA_W-1 -: RA_W];
  assign AA = ir[2*RA_W-1 -: RA_W];
  assign BA = ir[RA_W-1:0];

  // Branch offset {DA,AA} is signed; resizing a signed value sign-extends or
  // truncates to the PC width, giving modular PC arithmetic either way.
  assign br_off      = {DA, AA};
  assign br_target   = PC + PC_W'(br_off);
  assign jmp_target  = A[PC_W-1:0];
  assign unused_a_hi = ^A[NBIT-1:PC_W];

  assign mem_wait  = is_mem_op(op) && !mem_ready;
  assign stk_push  = (state == ST_EXEC) && (op == OP_CALL) && !stk_full;
  assign stk_pop   = (state == ST_EXEC) && (op == OP_RET) && !stk_empty;
  assign stk_fault = (state == ST_EXEC) &&
                     (((op == OP_CALL) && stk_full) || ((op == OP_RET) && stk_empty));

  call_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_call_stack (
    .clk   (clk),
    .reset (reset),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (PC),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: EXEC holds on a memory wait, HALT is left only by reset
  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT:   state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if ((op == OP_HALT) || stk_fault) state_nxt = ST_HALT;
        else if (mem_wait)                state_nxt = ST_EXEC;
        else                              state_nxt = ST_FETCH;
      end
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_BOOT;
    endcase
  end

  // Program counter, instruction register and sticky stack error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC        <= '0;
      PC_prev   <= '0;
      ir        <= '0;
      stack_err <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          ir      <= data_from_rom;
          PC_prev <= PC;
          PC      <= PC + PC_W'(1);
        end
        ST_EXEC: begin
          case (op)
            OP_BRZ:  if (zero_flag) PC <= br_target;
            OP_JMP:  PC <= jmp_target;
            OP_CALL: if (stk_full) stack_err <= 1'b1; else PC <= jmp_target;
            OP_RET:  if (stk_empty) stack_err <= 1'b1; else PC <= stk_top;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Moore control outputs decoded from state and IR
  always_comb begin
    IL   = 1'b0;
    RW   = 1'b0;
    MB   = 1'b0;
    MD   = 1'b0;
    MM   = 1'b0;
    MW   = 1'b0;
    FS   = FS_ADD;
    done = (state == ST_HALT);
    case (state)
      ST_FETCH: IL = 1'b1;
      ST_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL: begin
            FS = alu_fs(op);
            RW = 1'b1;
          end
          OP_ADDI: begin
            FS = FS_ADD;
            MB = 1'b1;
            RW = 1'b1;
          end
          OP_LD: begin
            MM = 1'b1;
            MD = 1'b1;
            RW = 1'b1;
          end
          OP_ST: begin
            MM = 1'b1;
            MW = 1'b1;
          end
          OP_HALT: done = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller (STACK_DEPTH=2).
module tb_multicycle_controller;

  localparam int NBIT        = 16;
  localparam int PC_W        = 6;
  localparam int RA_W        = 4;
  localparam int STACK_DEPTH = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NBIT-1:0] data_from_rom;
  logic [NBIT-1:0] A;
  logic            zero_flag;
  logic            mem_ready;
  logic [PC_W-1:0] PC, PC_prev;
  logic [RA_W-1:0] DA, AA, BA;
  logic [2:0]      FS;
  logic            IL, RW, MB, MD, MM, MW, done, stack_err;

  logic [NBIT-1:0] rom [64];

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       il;
    logic       rw;
    logic [2:0] fs;
    logic [3:0] da;
    logic       done;
    logic [5:0] pc;
  } cyc_t;

  typedef struct packed {
    logic [2:0] fs;
    logic       rw;
    logic       mb;
    logic       md;
    logic       mm;
    logic       mw;
  } ctl_t;

  typedef struct packed {
    logic       il;
    logic       mm;
    logic       md;
    logic       rw;
    logic [5:0] pc;
  } mem_t;

  cyc_t       cyc_q[$];
  ctl_t       ctl_q[$];
  mem_t       mem_q[$];
  logic [5:0] pc_q[$];

  always #5 clk = ~clk;

  assign data_from_rom = rom[PC];

  multicycle_controller #(
    .NBIT        (NBIT),
    .PC_W        (PC_W),
    .RA_W        (RA_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_from_rom (data_from_rom),
    .A             (A),
    .zero_flag     (zero_flag),
    .mem_ready     (mem_ready),
    .PC            (PC),
    .PC_prev       (PC_prev),
    .DA            (DA),
    .AA            (AA),
    .BA            (BA),
    .FS            (FS),
    .IL            (IL),
    .RW            (RW),
    .MB            (MB),
    .MD            (MD),
    .MM            (MM),
    .MW            (MW),
    .done          (done),
    .stack_err     (stack_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
  endtask

  // Leaves the bench in cycle 1 (BOOT) just after reset release
  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_fetch(input int budget, output bit ok, output int waited);
    ok     = 1'b0;
    waited = 0;
    for (int i = 0; i <= budget; i++) begin
      if (IL === 1'b1) begin
        ok     = 1'b1;
        waited = i;
        break;
      end
      if (i < budget) step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    vectors++;
    if ({IL, RW, MB, MD, MM, MW} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_enables: got %b expected %b", {IL, RW, MB, MD, MM, MW}, 6'b0);
    end
    vectors++;
    if ({done, stack_err} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_status: got %b expected %b", {done, stack_err}, 2'b00);
    end
    vectors++;
    if ({PC, PC_prev} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_pc: got %h expected %h", {PC, PC_prev}, 12'h000);
    end
    vectors++;
    if ({DA, AA, BA, FS} !== 15'h0) begin
      miscompares++;
      $display("FAIL reset_fields: got %h expected %h", {DA, AA, BA, FS}, 15'h0);
    end
  endtask

  task automatic test_add_halt();
    cyc_t e, act;
    int   n;
    clear_rom();
    rom[0] = 16'h1123;  // ADD R1,R2,R3
    rom[1] = 16'hF000;  // HALT
    cyc_q.push_back(cyc_t'{1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 6'd0});  // c1 BOOT
    cyc_q.push_back(cyc_t'{1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 6'd0});  // c2 FETCH
    cyc_q.push_back(cyc_t'{1'b0, 1'b0, 3'd0, 4'd1, 1'b0, 6'd1});  // c3 DECODE
    cyc_q.push_back(cyc_t'{1'b0, 1'b1, 3'd0, 4'd1, 1'b0, 6'd1});  // c4 EXEC ADD
    cyc_q.push_back(cyc_t'{1'b1, 1'b0, 3'd0, 4'd1, 1'b0, 6'd1});  // c5 FETCH
    cyc_q.push_back(cyc_t'{1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 6'd2});  // c6 DECODE
    for (int i = 0; i < 4; i++)                                   // c7..c10
      cyc_q.push_back(cyc_t'{1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 6'd2});
    apply_reset();
    n = 1;
    while (cyc_q.size() > 0) begin
      e   = cyc_q.pop_front();
      act = {IL, RW, FS, DA, done, PC};
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL add_halt_cycle%0d: got il/rw/fs/da/done/pc=%h expected %h", n, act, e);
      end
      n++;
      step();
    end
  endtask

  task automatic test_decode();
    ctl_t e, act;
    bit   ok;
    int   waited;
    clear_rom();
    rom[0] = 16'h2234;  // SUB
    rom[1] = 16'h7100;  // SHL
    rom[2] = 16'h8507;  // ADDI R5,R0,#7
    rom[3] = 16'hA012;  // ST
    rom[4] = 16'hF000;  // HALT
    mem_ready = 1'b1;
    ctl_q.push_back(ctl_t'{3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    ctl_q.push_back(ctl_t'{3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    ctl_q.push_back(ctl_t'{3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    ctl_q.push_back(ctl_t'{3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    apply_reset();
    while (ctl_q.size() > 0) begin
      wait_fetch(8, ok, waited);
      e = ctl_q.pop_front();
      if (!ok) begin
        vectors++;
        miscompares++;
        $display("FAIL decode_timeout: got no fetch expected fetch within 8 cycles");
        break;
      end
      step();
      step();
      act = {FS, RW, MB, MD, MM, MW};
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL decode_exec: got fs/rw/mb/md/mm/mw=%b expected %b", act, e);
      end
      step();
    end
    vectors++;
    if ({IL, PC} !== {1'b1, 6'd4}) begin
      miscompares++;
      $display("FAIL decode_st_no_wait: got il/pc=%b/%0d expected 1/4", IL, PC);
    end
  endtask

  task automatic test_ld_wait();
    mem_t e, act;
    clear_rom();
    rom[0] = 16'h9120;  // LD R1,R2
    rom[1] = 16'hF000;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) mem_q.push_back(mem_t'{1'b0, 1'b1, 1'b1, 1'b1, 6'd1});
    mem_q.push_back(mem_t'{1'b1, 1'b0, 1'b0, 1'b0, 6'd1});
    apply_reset();
    step();
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 3) mem_ready = 1'b1;
      e   = mem_q.pop_front();
      act = {IL, MM, MD, RW, PC};
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL ld_wait_cycle%0d: got il/mm/md/rw/pc=%h expected %h", i, act, e);
      end
      step();
    end
  endtask

  task automatic test_branch(input logic zf);
    bit         ok;
    int         waited;
    logic [5:0] e, last;
    clear_rom();
    rom[5] = 16'hBFE0;  // BRZ offset -2
    rom[6] = 16'hF000;
    zero_flag = zf;
    for (int i = 0; i <= 5; i++) pc_q.push_back(6'(i));
    if (zf) begin
      pc_q.push_back(6'd4);
      pc_q.push_back(6'd5);
    end else begin
      pc_q.push_back(6'd6);
    end
    apply_reset();
    last = 6'd0;
    while (pc_q.size() > 0) begin
      wait_fetch(8, ok, waited);
      e = pc_q.pop_front();
      vectors++;
      if (!ok || PC !== e) begin
        miscompares++;
        $display("FAIL branch_zf%0b_fetch: got pc=%0d ok=%0b expected %0d", zf, PC, ok, e);
        pc_q.delete();
        break;
      end
      if (last == 6'd5) begin
        vectors++;
        if (waited + 1 != 3) begin
          miscompares++;
          $display("FAIL branch_zf%0b_cpi: got %0d cycles expected 3", zf, waited + 1);
        end
      end
      last = PC;
      step();
    end
    zero_flag = 1'b0;
  endtask

  task automatic test_wrap_jmp();
    bit         ok;
    int         waited;
    int         n;
    logic [5:0] e;
    clear_rom();
    rom[0]  = 16'hC000;  // JMP A
    rom[37] = 16'hF000;
    A = 16'h003E;
    pc_q.push_back(6'd0);
    pc_q.push_back(6'd62);
    pc_q.push_back(6'd63);
    pc_q.push_back(6'd0);
    pc_q.push_back(6'd37);
    apply_reset();
    n = 0;
    while (pc_q.size() > 0) begin
      wait_fetch(8, ok, waited);
      e = pc_q.pop_front();
      vectors++;
      if (!ok || PC !== e) begin
        miscompares++;
        $display("FAIL wrap_jmp_fetch%0d: got pc=%0d ok=%0b expected %0d", n, PC, ok, e);
        pc_q.delete();
        break;
      end
      n++;
      if (n == 4) A = 16'h0025;
      step();
    end
    step();
    step();
    vectors++;
    if ({done, PC} !== {1'b1, 6'd38}) begin
      miscompares++;
      $display("FAIL wrap_jmp_halt: got done/pc=%b/%0d expected 1/38", done, PC);
    end
  endtask

  task automatic test_call_ret();
    bit         ok;
    int         waited;
    logic [5:0] e;
    clear_rom();
    rom[0] = 16'hD000;  // CALL 8
    rom[1] = 16'hF000;
    rom[8] = 16'hE000;  // RET
    A = 16'h0008;
    pc_q.push_back(6'd0);
    pc_q.push_back(6'd8);
    pc_q.push_back(6'd1);
    apply_reset();
    while (pc_q.size() > 0) begin
      wait_fetch(8, ok, waited);
      e = pc_q.pop_front();
      vectors++;
      if (!ok || PC !== e) begin
        miscompares++;
        $display("FAIL call_ret_fetch: got pc=%0d ok=%0b expected %0d", PC, ok, e);
        pc_q.delete();
        break;
      end
      step();
    end
    step();
    step();
    vectors++;
    if ({done, stack_err, PC} !== {1'b1, 1'b0, 6'd2}) begin
      miscompares++;
      $display("FAIL call_ret_halt: got done/err/pc=%b/%b/%0d expected 1/0/2", done, stack_err, PC);
    end
  endtask

  task automatic test_stack_overflow();
    bit         ok;
    int         waited;
    logic [5:0] e;
    clear_rom();
    rom[0]  = 16'hD000;
    rom[10] = 16'hD000;
    A = 16'h000A;
    pc_q.push_back(6'd0);
    pc_q.push_back(6'd10);
    pc_q.push_back(6'd10);
    apply_reset();
    while (pc_q.size() > 0) begin
      wait_fetch(8, ok, waited);
      e = pc_q.pop_front();
      vectors++;
      if (!ok || PC !== e) begin
        miscompares++;
        $display("FAIL overflow_fetch: got pc=%0d ok=%0b expected %0d", PC, ok, e);
        pc_q.delete();
        break;
      end
      step();
    end
    step();
    vectors++;
    if ({stack_err, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL overflow_exec: got err/done=%b expected 00", {stack_err, done});
    end
    step();
    vectors++;
    if ({stack_err, done, PC} !== {1'b1, 1'b1, 6'd11}) begin
      miscompares++;
      $display("FAIL overflow_halt: got err/done/pc=%b/%b/%0d expected 1/1/11", stack_err, done, PC);
    end
    step();
    vectors++;
    if ({IL, PC} !== {1'b0, 6'd11}) begin
      miscompares++;
      $display("FAIL overflow_frozen: got il/pc=%b/%0d expected 0/11", IL, PC);
    end
  endtask

  task automatic test_ret_empty();
    clear_rom();
    rom[0] = 16'hE000;
    apply_reset();
    step();
    step();
    step();
    step();
    vectors++;
    if ({stack_err, done, PC} !== {1'b1, 1'b1, 6'd1}) begin
      miscompares++;
      $display("FAIL ret_empty: got err/done/pc=%b/%b/%0d expected 1/1/1", stack_err, done, PC);
    end
  endtask

  task automatic test_reset_mid();
    clear_rom();
    rom[0] = 16'h9120;
    mem_ready = 1'b0;
    apply_reset();
    step();
    step();
    step();
    step();
    vectors++;
    if ({MM, MD, RW} !== 3'b111) begin
      miscompares++;
      $display("FAIL reset_mid_pre: got mm/md/rw=%b expected 111", {MM, MD, RW});
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({IL, RW, MB, MD, MM, MW, done, stack_err, FS, PC, PC_prev, DA, AA, BA} !== 35'h0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got %h expected 0",
               {IL, RW, MB, MD, MM, MW, done, stack_err, FS, PC, PC_prev, DA, AA, BA});
    end
    step();
    reset = 1'b0;
    vectors++;
    if ({IL, RW, PC} !== {1'b0, 1'b0, 6'd0}) begin
      miscompares++;
      $display("FAIL reset_mid_boot: got il/rw/pc=%b/%b/%0d expected 0/0/0", IL, RW, PC);
    end
    step();
    vectors++;
    if ({IL, PC} !== {1'b1, 6'd0}) begin
      miscompares++;
      $display("FAIL reset_mid_fetch: got il/pc=%b/%0d expected 1/0", IL, PC);
    end
    mem_ready = 1'b1;
  endtask

  initial begin
    reset     = 1'b1;
    A         = '0;
    zero_flag = 1'b0;
    mem_ready = 1'b1;
    clear_rom();
    test_reset();
    test_add_halt();
    test_decode();
    test_ld_wait();
    test_branch(1'b1);
    test_branch(1'b0);
    test_wrap_jmp();
    test_call_ret();
    test_stack_overflow();
    test_ret_empty();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
